// File: rtl/dm_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding and master ids.
// Used by the RTL and by the testbench.
package dm_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-requester winner picker (combinational).
// When DM_ARB_FIXED_PRIO_EN is defined, m0 always wins a tie and prio is ignored.
module rr_pick2
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = M0;
    if (req == 2'b11) begin
`ifdef DM_ARB_FIXED_PRIO_EN
      winner = M0;
`else
      winner = prio;
`endif
    end else if (req[1]) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between m0 and m1.
// Define DM_ARB_FIXED_PRIO_EN to make m0 always win simultaneous requests.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [31:0]       m0_pc,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [31:0]       m1_pc,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [31:0]       dm_pc,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_t        state, state_next;
  logic              prio;
  logic              pick_id, pick_valid;
  logic              own_id, own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [31:0]       own_pc;

  rr_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .prio   (prio),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched payload keeps driving the DM port between accesses; only dm_we is qualified.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= M0;
      own_id    <= M0;
      own_we    <= 1'b0;
      own_addr  <= '0;
      own_wdata <= '0;
      own_pc    <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (state == IDLE && pick_valid) begin
        own_id    <= pick_id;
        own_we    <= pick_id ? m1_we : m0_we;
        own_addr  <= (pick_id ? m1_addr : m0_addr) & WORD_MASK;
        own_wdata <= pick_id ? m1_wdata : m0_wdata;
        own_pc    <= pick_id ? m1_pc : m0_pc;
`ifndef DM_ARB_FIXED_PRIO_EN
        prio      <= ~pick_id;
`endif
      end
      if (state == ACCESS) begin
        if (own_id == M1) begin
          m1_rdata  <= own_we ? '0 : dm_rdata;
          m1_rvalid <= 1'b1;
        end else begin
          m0_rdata  <= own_we ? '0 : dm_rdata;
          m0_rvalid <= 1'b1;
        end
      end
    end
  end

  assign m0_gnt   = (state == ACCESS) && (own_id == M0);
  assign m1_gnt   = (state == ACCESS) && (own_id == M1);
  assign dm_we    = (state == ACCESS) && own_we && !reset;
  assign dm_addr  = own_addr;
  assign dm_wdata = own_wdata;
  assign dm_pc    = own_pc;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline's MEM-stage master (m0) and a secondary master (m1, loader/debug bridge). It accepts word-wide requests over a req/gnt handshake, picks a winner round-robin, and drives the DM's address, write-data and write-enable for exactly one access cycle. It returns read data or a write-completion pulse one cycle later. It sits between the requesters and DM; DM's combinational read port feeds `dm_rdata`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_req`, `m1_req`  in  1  request; held with payload stable until `mX_gnt` is seen high
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address (word access)
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_pc`, `m1_pc`  in  32  PC+4 tag of the issuing instruction, forwarded for DM trace
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse during the owner's access cycle
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle completion pulse (reads and writes)
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data, valid with `rvalid`; 0 for writes
- `dm_addr`  out  ADDR_W  to DM, bits [1:0] forced to 0
- `dm_wdata`  out  DATA_W  to DM
- `dm_we`  out  1  to DM write enable
- `dm_pc`  out  32  to DM PC tag
- `dm_rdata`  in  DATA_W  from DM combinational read

## Operation
- FSM states: IDLE, ACCESS. Reset → IDLE.
- IDLE: arbitration happens at the clock edge.
  - If no request, stay in IDLE.
  - Otherwise latch the winner's id, we, addr, wdata and pc, then go to ACCESS.
- Winner selection:
  - Only one `req` high: that master wins.
  - Both high: the master indicated by `prio` wins.
  - `prio` flips to the other master after every grant.
- ACCESS:
  - Owner's `gnt` = 1.
  - `dm_*` driven from the latched registers.
  - `dm_we` = latched we & !reset.
- At the end of ACCESS: capture `dm_rdata` (or 0 for writes) into the owner's `rdata` register, pulse the owner's `rvalid` in the following cycle, and always return to IDLE.
- Requesters drop or renew `req` in the cycle after `gnt`. Because arbitration occurs only in IDLE, an access is never double-served.
- Outside ACCESS, `dm_we` = 0 and `dm_addr`/`dm_wdata`/`dm_pc` hold their last latched values.
- Non-owner's `rdata` and `rvalid` are unaffected by the other master's access.

## Timing
- Reset values:
  - state IDLE, `prio` = 0 (m0 favoured)
  - all `gnt`/`rvalid` 0, all `rdata` 0
  - `dm_addr`/`dm_wdata`/`dm_pc` 0, `dm_we` 0
- Latency:
  - `req` high in IDLE cycle N → `gnt` and DM access in N+1.
  - DM write commits at end of N+1.
  - `rvalid`/`rdata` in N+2.
- Throughput: one access per 2 cycles. A pending request gets its grant in N+3 at the earliest.
- Reset during ACCESS: `dm_we` is gated low in the same cycle, so no write commits. The next cycle is IDLE with no `rvalid`.
- Reset in the `rvalid` cycle: the pulse still appears (it was registered); all outputs clear from the next cycle.
- A request asserted during ACCESS waits until IDLE and is then arbitrated with `prio` already updated.

## Configuration
- `DM_ARB_FIXED_PRIO_EN`:
  - Defined: m0 always wins simultaneous requests and `prio` is not updated.
  - Undefined: round-robin as above.
- Both builds keep identical ports and latency.

## Structure
- Shared constants include: state encodings (IDLE = 1'b0, ACCESS = 1'b1) and master ids (M0 = 1'b0, M1 = 1'b1). It is shared with the benches.
- One natural sub-module, `rr_pick2`. It is purely combinational: it takes `req[1:0]` and `prio` and returns the winner id and a valid flag. The fixed-priority macro is applied inside it.

## Test plan
- Single read: preload DM[0x10] = 0xDEADBEEF, m0 reads 0x00000010 → `m0_gnt` in N+1, `m0_rvalid` with `m0_rdata` = 0xDEADBEEF in N+2.
- Write then read: m1 writes 0x12345678 to 0x00000024 (`m1_pc` = 0x3008). Check `dm_we` = 1 only in N+1 and `dm_pc` = 0x3008. A subsequent m0 read of 0x24 returns 0x12345678.
- Contention, round-robin: both request from reset → grant order m0, m1, m0, m1 on cycles 1, 3, 5, 7.
- Contention with `DM_ARB_FIXED_PRIO_EN`: m0 holds req continuously and m1 also requests → m1 never granted while m0 keeps requesting.
- Reset in ACCESS: m0 write of 0xCAFEF00D to 0x8, assert reset in the grant cycle → DM[0x8] unchanged, no `rvalid`, all outputs 0 the cycle after reset.
- Unaligned address: m1 reads 0x00000013 → `dm_addr` = 0x00000010.
